periferico_uart_tx: RTL and testbench

- Memory-mapped UART transmitter; a bus responder on the CPU data-memory interface (`dir`, `dat_escritura`, `hab_escritura`, `dat_lectura`), in parallel with the RAM.
- Selected by an external address decoder through `sel`.
- Software writes bytes into a small FIFO; a baud-rate FSM serialises them as 8N1, LSB first, on `tx`.
- Reads follow the RAM's timing: data is registered and valid one cycle after the address.

---
 rtl/uart_tx_pkg.sv | 24 ++
 rtl/fifo_sincrona.sv | 46 ++++
 rtl/periferico_uart_tx.sv | 159 +++++++++++++++
 tb/tb_periferico_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// status/control bit positions and FSM encoding.
package uart_tx_pkg;
  localparam logic [1:0] REG_DATO    = 2'd0;
  localparam logic [1:0] REG_ESTADO  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int EST_VACIA    = 0;
  localparam int EST_LLENA    = 1;
  localparam int EST_OCUPADO  = 2;
  localparam int EST_DESBORDE = 3;

  localparam int CTL_HAB      = 0;
  localparam int CTL_FLUSH    = 1;
  localparam int CTL_CLR_DESB = 2;

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    INICIO = 2'd1,
    DATOS  = 2'd2,
    PARADA = 2'd3
  } estado_e;
endpackage

// File: rtl/fifo_sincrona.sv
// Single-clock FIFO with flush; a push into a full FIFO is accepted only when
// a pop happens in the same cycle.
module fifo_sincrona #(
  parameter int PROFUNDIDAD = 8,
  parameter int ANCHO       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [ANCHO-1:0] din,
  output logic [ANCHO-1:0] dout,
  output logic             vacia,
  output logic             llena
);
  localparam int AW = $clog2(PROFUNDIDAD);

  logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign vacia   = (cnt_q == '0);
  assign llena   = (cnt_q == (AW+1)'(PROFUNDIDAD));
  assign do_push = push && (!llena || pop);
  assign do_pop  = pop && !vacia;
  assign dout    = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/periferico_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, registered read mux,
// byte FIFO and baud-rate serialiser FSM.
module periferico_uart_tx
  import uart_tx_pkg::*;
#(
  parameter int          PROFUNDIDAD = 8,
  parameter logic [15:0] DIV_RESET   = 16'd433
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [31:0] dir,
  input  logic [31:0] dat_escritura,
  input  logic        hab_escritura,
  output logic [31:0] dat_lectura,
  output logic        tx
);
  logic [1:0]  idx;
  logic        wr, wr_dato, wr_div, wr_ctl, flush;
  logic [15:0] div_q;
  logic        hab_q, desb_q;
  logic [31:0] rd_d, dat_lectura_q;

  estado_e     estado_q, estado_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        pop, fin_bit;

  logic [7:0]  dout;
  logic        vacia, llena;
  logic        unused_ok;

  assign unused_ok = ^{dir[31:4], dir[1:0], dat_escritura[31:16]};

  assign idx     = dir[3:2];
  assign wr      = sel && hab_escritura;
  assign wr_dato = wr && (idx == REG_DATO);
  assign wr_div  = wr && (idx == REG_DIVISOR);
  assign wr_ctl  = wr && (idx == REG_CONTROL);
  assign flush   = wr_ctl && dat_escritura[CTL_FLUSH];
  assign fin_bit = (cnt_q == 16'd0);

  fifo_sincrona #(.PROFUNDIDAD(PROFUNDIDAD), .ANCHO(8)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_dato),
    .pop   (pop),
    .flush (flush),
    .din   (dat_escritura[7:0]),
    .dout  (dout),
    .vacia (vacia),
    .llena (llena)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= DIV_RESET;
      hab_q  <= 1'b1;
      desb_q <= 1'b0;
    end else begin
      if (wr_div) div_q <= dat_escritura[15:0];
      if (wr_ctl) hab_q <= dat_escritura[CTL_HAB];
      if (wr_ctl && dat_escritura[CTL_CLR_DESB]) desb_q <= 1'b0;
      else if (wr_dato && llena && !pop)         desb_q <= 1'b1;
    end
  end

  always_comb begin
    rd_d = '0;
    case (idx)
      REG_ESTADO: begin
        rd_d[EST_VACIA]    = vacia;
        rd_d[EST_LLENA]    = llena;
        rd_d[EST_OCUPADO]  = (estado_q != REPOSO);
        rd_d[EST_DESBORDE] = desb_q;
      end
      REG_DIVISOR: rd_d[15:0]     = div_q;
      REG_CONTROL: rd_d[CTL_HAB]  = hab_q;
      default:     rd_d           = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)    dat_lectura_q <= '0;
    else if (sel) dat_lectura_q <= rd_d;
  end

  // State register; tx is registered from the next-state decode so it never glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= REPOSO;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q - 16'd1;
    bit_d    = bit_q;
    shift_d  = shift_q;
    pop      = 1'b0;
    case (estado_q)
      REPOSO: begin
        cnt_d = cnt_q;
        if (hab_q && !vacia) begin
          pop      = 1'b1;
          shift_d  = dout;
          cnt_d    = div_q;
          estado_d = INICIO;
        end
      end
      INICIO: if (fin_bit) begin
        estado_d = DATOS;
        bit_d    = 3'd0;
        cnt_d    = div_q;
      end
      DATOS: if (fin_bit) begin
        cnt_d   = div_q;
        shift_d = shift_q >> 1;
        if (bit_q == 3'd7) estado_d = PARADA;
        else               bit_d    = bit_q + 3'd1;
      end
      PARADA: if (fin_bit) begin
        // Chain straight into the next start bit so queued bytes leave no idle gap.
        if (hab_q && !vacia) begin
          pop      = 1'b1;
          shift_d  = dout;
          cnt_d    = div_q;
          estado_d = INICIO;
        end else begin
          estado_d = REPOSO;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_comb begin
    case (estado_d)
      INICIO:  tx_d = 1'b0;
      DATOS:   tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx          = tx_q;
  assign dat_lectura = dat_lectura_q;
endmodule

// File: tb/tb_periferico_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames and register values, a
// negedge monitor decodes tx and bus reads and compares them.
module tb_periferico_uart_tx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] dir = '0;
  logic [31:0] dat_escritura = '0;
  logic        hab_escritura = 1'b0;
  logic [31:0] dat_lectura;
  logic        tx;

  periferico_uart_tx dut (
    .clk(clk), .reset(reset), .sel(sel), .dir(dir),
    .dat_escritura(dat_escritura), .hab_escritura(hab_escritura),
    .dat_lectura(dat_lectura), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]      b;
    logic [9:0][7:0] per;   // cycles for start, b0..b7, stop
  } frame_t;

  typedef struct {
    string       nm;
    int          kind;      // 0 read data, 1 tx level, 2 pending frames
    logic [31:0] exp;
  } chk_t;

  frame_t sbq[$];
  chk_t   chq[$];
  int     total = 0, bad = 0;

  bit     busy = 0, gap_en = 0, errb = 0, prev_tx = 1;
  logic   errval, expval;
  int     bi = 0, cyc = 0, idle_run = 0, burst = 0;
  frame_t cur;

  function automatic frame_t mkf(input logic [7:0] b, input int plo, input int phi, input int sw);
    frame_t f;
    f.b = b;
    for (int i = 0; i < 10; i++) f.per[i] = 8'((i < sw) ? plo : phi);
    return f;
  endfunction

  function automatic logic level(input frame_t f, input int i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return f.b[i-1];
  endfunction

  always @(negedge clk) begin
    while (chq.size() > 0) begin
      chk_t  c;
      logic [31:0] act;
      c = chq.pop_front();
      act = (c.kind == 0) ? dat_lectura : (c.kind == 1) ? {31'b0, tx} : 32'(sbq.size() + int'(busy));
      total++;
      if (act !== c.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", c.nm, act, c.exp);
      end
    end
    if (reset) begin
      busy = 0;
      sbq.delete();
      prev_tx = 1;
    end else begin
      if (!gap_en) burst = 0;
      if (!busy) begin
        if (prev_tx && tx === 1'b0) begin
          if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_frame: got start bit expected idle line");
          end else begin
            cur = sbq.pop_front();
            busy = 1; bi = 0; cyc = 0; errb = 0;
            if (gap_en && burst > 0) begin
              total++;
              if (idle_run != 0) begin
                bad++;
                $display("FAIL frame_gap: got %0d idle cycles expected 0", idle_run);
              end
            end
            burst++;
          end
        end else if (tx === 1'b1) idle_run++;
      end
      if (busy) begin
        expval = level(cur, bi);
        if (tx !== expval && !errb) begin errb = 1; errval = tx; end
        cyc++;
        if (cyc == int'(cur.per[bi])) begin
          total++;
          if (errb) begin
            bad++;
            $display("FAIL frame_%02h_bit%0d: got tx=%b expected %b", cur.b, bi, errval, expval);
          end
          bi++; cyc = 0; errb = 0;
          if (bi == 10) begin busy = 0; idle_run = 0; end
        end
      end
      prev_tx = tx;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1; hab_escritura = 1; dir = {28'b0, a, 2'b0}; dat_escritura = d;
    @(posedge clk); #1;
    sel = 0; hab_escritura = 0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input string nm);
    sel = 1; hab_escritura = 0; dir = {28'b0, a, 2'b0};
    @(posedge clk); #1;
    sel = 0;
    chq.push_back('{nm, 0, e});
  endtask

  task automatic chk_tx(input logic e, input string nm);
    chq.push_back('{nm, 1, {31'b0, e}});
  endtask

  task automatic wait_idle(input int budget, input string nm);
    for (int i = 0; i < budget && (sbq.size() != 0 || busy); i++) @(posedge clk);
    #1;
    chq.push_back('{nm, 2, 32'd0});
  endtask

  initial begin
    logic [7:0] b;
    int d, n;

    repeat (3) @(posedge clk);
    #1;
    chk_tx(1'b1, "reset_tx");
    chq.push_back('{"reset_rdata", 0, 32'h0});
    reset = 0;
    rd(2'd0, 32'h0,   "rst_dato");
    rd(2'd1, 32'h1,   "rst_estado");
    rd(2'd2, 32'h1B1, "rst_divisor");
    rd(2'd3, 32'h1,   "rst_control");
    chk_tx(1'b1, "idle_tx");

    // Latency and basic frame
    wr(2'd2, 32'd3);
    sbq.push_back(mkf(8'h55, 4, 4, 10));
    wr(2'd0, 32'h55);
    chk_tx(1'b1, "tx_before_fall");
    @(posedge clk); #1;
    chk_tx(1'b0, "tx_fall_n1");
    wait_idle(200, "drain_55");
    rd(2'd1, 32'h1, "estado_after_55");

    // Fill with HAB=0, overflow, then burst with no gaps
    wr(2'd2, 32'd0);
    wr(2'd3, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sbq.push_back(mkf(8'(i), 1, 1, 10));
      wr(2'd0, 32'(i));
    end
    rd(2'd1, 32'h2, "estado_full");
    wr(2'd0, 32'h08);
    rd(2'd1, 32'hA, "estado_overflow");
    gap_en = 1;
    wr(2'd3, 32'h5);
    wait_idle(300, "drain_burst");
    gap_en = 0;
    rd(2'd1, 32'h1, "estado_after_burst");

    // Divisor change during bit 2
    wr(2'd2, 32'd3);
    sbq.push_back(mkf(8'hA3, 4, 8, 4));
    wr(2'd0, 32'hA3);
    repeat (13) @(posedge clk);
    #1;
    wr(2'd2, 32'd7);
    wait_idle(300, "drain_a3");
    rd(2'd2, 32'h7, "divisor_7");

    // Flush during the first of three queued frames
    wr(2'd2, 32'd3);
    sbq.push_back(mkf(8'hC4, 4, 4, 10));
    wr(2'd0, 32'hC4);
    wr(2'd0, 32'h11);
    wr(2'd0, 32'h22);
    repeat (8) @(posedge clk);
    #1;
    wr(2'd3, 32'h3);
    rd(2'd1, 32'h5, "estado_after_flush");
    wait_idle(300, "drain_flush");
    repeat (60) @(posedge clk);
    #1;
    rd(2'd1, 32'h1, "estado_flush_done");

    // Reset in the middle of the data bits
    sbq.push_back(mkf(8'h3C, 4, 4, 10));
    wr(2'd0, 32'h3C);
    repeat (10) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk_tx(1'b1, "tx_after_reset");
    rd(2'd1, 32'h1,   "estado_after_reset");
    rd(2'd2, 32'h1B1, "divisor_after_reset");
    wr(2'd2, 32'd2);
    b = 8'($urandom);
    sbq.push_back(mkf(b, 3, 3, 10));
    wr(2'd0, {24'b0, b});
    wait_idle(200, "drain_post_reset");

    // Random rounds
    for (int r = 0; r < 4; r++) begin
      d = int'($urandom_range(0, 4));
      n = int'($urandom_range(1, 6));
      wr(2'd2, 32'(d));
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        sbq.push_back(mkf(b, d + 1, d + 1, 10));
        wr(2'd0, {24'b0, b});
      end
      wait_idle(2000, "drain_random");
      rd(2'd1, 32'h1, "estado_random");
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
